// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter: FSM states,
// transaction word geometry and a byte-slice helper.
package spi_arb_pkg;

    localparam int SPI_WORDS = 4;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = SPI_WORDS * BYTE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Byte k of a packed transaction word; byte 0 sits in the low bits.
    function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] w, input int k);
        return w[k*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, searching upward with wrap-around.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sequencer sharing one 4-word SPI controller among N_REQ
// requesters, with a watchdog on the controller's done and per-slave SS routing.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IW             = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   req_tx_data,
    input  logic [N_REQ*2-1:0]        req_words,
    input  logic [N_REQ-1:0]          req_tied_ss,
    output logic [N_REQ-1:0]          gnt,
    output logic                      rsp_valid,
    output logic [IW-1:0]             rsp_id,
    output logic [WORD_W-1:0]         rsp_rx_data,
    output logic                      rsp_err,
    output logic                      ctrl_start,
    output logic [WORD_W-1:0]         ctrl_tx_data,
    output logic [1:0]                ctrl_words,
    output logic                      ctrl_tied_ss,
    input  logic [WORD_W-1:0]         ctrl_rx_data,
    input  logic                      ctrl_done,
    input  logic                      ctrl_ss,
    output logic [N_REQ-1:0]          ss_n
);

    localparam int           TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Handshake: req[i] is a level held until rsp_valid with rsp_id==i; the
    // response is a single-cycle pulse with no backpressure. The controller
    // side is start-pulse / done-pulse, qualified only while BUSY.

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [1:0]        words_q, words_d;
    logic              tied_q, tied_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic              err_q, err_d;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [WORD_W-1:0] win_word;
    int                sel;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        tx_d     = tx_q;
        words_d  = words_q;
        tied_d   = tied_q;
        timer_d  = timer_q;
        rx_d     = rx_q;
        err_d    = err_q;
        sel      = int'(pick_idx);
        win_word = req_tx_data[sel*WORD_W +: WORD_W];

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    words_d = req_words[sel*2 +: 2];
                    tied_d  = req_tied_ss[sel];
                    for (int k = 0; k < SPI_WORDS; k++) begin
                        tx_d[k*BYTE_W +: BYTE_W] = byte_of(win_word, k);
                    end
                    state_d = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // A done arriving on the last watchdog cycle still counts.
                if (ctrl_done) begin
                    rx_d    = ctrl_rx_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    rx_d    = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            tx_q    <= '0;
            words_q <= '0;
            tied_q  <= 1'b0;
            timer_q <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            tx_q    <= tx_d;
            words_q <= words_d;
            tied_q  <= tied_d;
            timer_q <= timer_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q != IDLE) begin
            gnt[idx_q] = 1'b1;
        end
    end

    // Only ss_n follows an input combinationally, so SS timing is the controller's.
    always_comb begin
        ss_n = '1;
        if (state_q == START || state_q == BUSY) begin
            ss_n[idx_q] = ctrl_ss;
        end
    end

    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = rsp_valid ? idx_q : '0;
    assign rsp_rx_data  = rx_q;
    assign rsp_err      = err_q;
    assign ctrl_start   = (state_q == START);
    assign ctrl_tx_data = tx_q;
    assign ctrl_words   = words_q;
    assign ctrl_tied_ss = tied_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a vector table of whole transactions
// against a small SPI controller model, plus reset-abort and mid-flight sequences.
module tb_spi_txn_arbiter;

    localparam int N   = 4;
    localparam int TMO = 48;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_tx_data;
    logic [7:0]   req_words;
    logic [3:0]   req_tied_ss;
    logic [3:0]   gnt;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_rx_data;
    logic         rsp_err;
    logic         ctrl_start;
    logic [31:0]  ctrl_tx_data;
    logic [1:0]   ctrl_words;
    logic         ctrl_tied_ss;
    logic [31:0]  ctrl_rx_data;
    logic         ctrl_done;
    logic         ctrl_ss;
    logic [3:0]   ss_n;

    int n_total;
    int n_pass;

    // Controller model knobs: done after model_delay BUSY cycles, 0 = never.
    int          model_delay;
    logic [31:0] model_rx;
    int          m_cnt;
    logic        m_busy;

    spi_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_tx_data  (req_tx_data),
        .req_words    (req_words),
        .req_tied_ss  (req_tied_ss),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_rx_data  (rsp_rx_data),
        .rsp_err      (rsp_err),
        .ctrl_start   (ctrl_start),
        .ctrl_tx_data (ctrl_tx_data),
        .ctrl_words   (ctrl_words),
        .ctrl_tied_ss (ctrl_tied_ss),
        .ctrl_rx_data (ctrl_rx_data),
        .ctrl_done    (ctrl_done),
        .ctrl_ss      (ctrl_ss),
        .ss_n         (ss_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        m_busy       = 1'b0;
        m_cnt        = 0;
        ctrl_done    = 1'b0;
        ctrl_ss      = 1'b1;
        ctrl_rx_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_busy    = 1'b0;
                ctrl_done = 1'b0;
                ctrl_ss   = 1'b1;
            end else begin
                ctrl_done = 1'b0;
                if (ctrl_start) begin
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    ctrl_ss = 1'b0;
                end else if (m_busy) begin
                    m_cnt = m_cnt + 1;
                    if (model_delay > 0 && m_cnt == model_delay) begin
                        ctrl_done    = 1'b1;
                        ctrl_rx_data = model_rx;
                        ctrl_ss      = 1'b1;
                        m_busy       = 1'b0;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [3:0]   req;
        logic [127:0] txd;
        logic [7:0]   words;
        logic [3:0]   tied;
        int           delay;
        logic [31:0]  rx;
        logic [1:0]   e_id;
        logic [31:0]  e_tx;
        logic [1:0]   e_words;
        logic         e_tied;
        logic         e_err;
        logic [31:0]  e_rx;
        logic [3:0]   e_ssn;
        int           e_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        req         = v.req;
        req_tx_data = v.txd;
        req_words   = v.words;
        req_tied_ss = v.tied;
        model_delay = v.delay;
        model_rx    = v.rx;
    endtask

    // Drives one vector and follows its transaction to the IDLE cycle after
    // RESP. At BUSY observation mod_at (if >0) the winner's req is dropped to
    // mod_req and all payload inputs are cleared.
    task automatic run_txn(input vec_t v, input int mod_at, input logic [3:0] mod_req);
        logic [3:0] oh;
        int         n;
        logic       got;
        oh = 4'b0001 << v.e_id;
        drive(v);
        @(posedge clk); #1;
        chk("start_pulse", {31'd0, ctrl_start}, 32'd1);
        chk("gnt_start", {28'd0, gnt}, {28'd0, oh});
        chk("ctrl_tx", ctrl_tx_data, v.e_tx);
        chk("ctrl_words", {30'd0, ctrl_words}, {30'd0, v.e_words});
        chk("ctrl_tied", {31'd0, ctrl_tied_ss}, {31'd0, v.e_tied});
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("ss_n_busy", {28'd0, ss_n}, {28'd0, v.e_ssn});
            chk("start_single", {31'd0, ctrl_start}, 32'd0);
            chk("gnt_busy", {28'd0, gnt}, {28'd0, oh});
            if (rsp_valid) got = 1'b1;
            if (n == mod_at) begin
                @(negedge clk);
                req         = mod_req;
                req_tx_data = '0;
                req_words   = '0;
                req_tied_ss = '0;
            end
        end
        chk("rsp_seen", {31'd0, got}, 32'd1);
        if (got) begin
            chk("latency", n, v.e_lat);
            chk("rsp_id", {30'd0, rsp_id}, {30'd0, v.e_id});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.e_err});
            chk("rsp_rx", rsp_rx_data, v.e_rx);
            chk("ctrl_tx_hold", ctrl_tx_data, v.e_tx);
            chk("ctrl_words_hold", {30'd0, ctrl_words}, {30'd0, v.e_words});
        end
        @(negedge clk);
        req[v.e_id] = 1'b0;
        @(posedge clk); #1;
        chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        chk("gnt_idle", {28'd0, gnt}, 32'd0);
        chk("rsp_rx_hold", rsp_rx_data, v.e_rx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t va;
        vec_t vb1;
        vec_t vb2;
        logic seen_rsp;
        n_total     = 0;
        n_pass      = 0;
        rst         = 1'b0;
        req         = '0;
        req_tx_data = '0;
        req_words   = '0;
        req_tied_ss = '0;
        model_delay = 0;
        model_rx    = '0;

        // Fairness (ptr starts at 0), single request, timeout, boundary done.
        vecs[0] = '{4'b1111, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 8'b11_10_01_00, 4'b1010, 5, 32'h000000F0,
                    2'd0, 32'hA0A0A0A0, 2'b00, 1'b0, 1'b0, 32'h000000F0, 4'b1110, 6};
        vecs[1] = '{4'b1111, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 8'b11_10_01_00, 4'b1010, 6, 32'h000000F1,
                    2'd1, 32'hB1B1B1B1, 2'b01, 1'b1, 1'b0, 32'h000000F1, 4'b1101, 7};
        vecs[2] = '{4'b1111, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 8'b11_10_01_00, 4'b1010, 2, 32'h000000F2,
                    2'd2, 32'hC2C2C2C2, 2'b10, 1'b0, 1'b0, 32'h000000F2, 4'b1011, 3};
        vecs[3] = '{4'b1111, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 8'b11_10_01_00, 4'b1010, 1, 32'h000000F3,
                    2'd3, 32'hD3D3D3D3, 2'b11, 1'b1, 1'b0, 32'h000000F3, 4'b0111, 2};
        vecs[4] = '{4'b1111, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 8'b11_10_01_00, 4'b1010, 4, 32'h000000F4,
                    2'd0, 32'hA0A0A0A0, 2'b00, 1'b0, 1'b0, 32'h000000F4, 4'b1110, 5};
        vecs[5] = '{4'b0100, 128'h00000000_A1B2C3D4_00000000_00000000, 8'b00_11_00_00, 4'b0000, 40, 32'h11223344,
                    2'd2, 32'hA1B2C3D4, 2'b11, 1'b0, 1'b0, 32'h11223344, 4'b1011, 41};
        vecs[6] = '{4'b0001, 128'h00000000_00000000_00000000_5A5A5A5A, 8'b00_00_00_01, 4'b0001, 0, 32'hDEADBEEF,
                    2'd0, 32'h5A5A5A5A, 2'b01, 1'b1, 1'b1, 32'h00000000, 4'b1110, TMO + 1};
        vecs[7] = '{4'b1001, 128'h76543210_00000000_00000000_01234567, 8'b10_00_00_11, 4'b0001, TMO, 32'hCAFEF00D,
                    2'd3, 32'h76543210, 2'b10, 1'b0, 1'b0, 32'hCAFEF00D, 4'b0111, TMO + 1};
        vecs[8] = '{4'b0110, 128'h00000000_89ABCDEF_13579BDF_00000000, 8'b00_01_11_00, 4'b0100, TMO + 1, 32'h0BADCAFE,
                    2'd1, 32'h13579BDF, 2'b11, 1'b0, 1'b1, 32'h00000000, 4'b1101, TMO + 1};
        vecs[9] = '{4'b0110, 128'h00000000_89ABCDEF_13579BDF_00000000, 8'b00_01_11_00, 4'b0100, 3, 32'h600DD00D,
                    2'd2, 32'h89ABCDEF, 2'b01, 1'b1, 1'b0, 32'h600DD00D, 4'b1011, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt", {28'd0, gnt}, 32'd0);
        chk("reset_ss_n", {28'd0, ss_n}, 32'hF);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_start", {31'd0, ctrl_start}, 32'd0);
        chk("reset_rsp_rx", rsp_rx_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], 0, 4'b0000);
        end

        // Reset while BUSY: transaction aborts silently, pointer returns to 0.
        va = '{4'b0010, 128'h00000000_00000000_0F0F0F0F_00000000, 8'b00_00_11_00, 4'b0010, 0, 32'h0,
               2'd1, 32'h0F0F0F0F, 2'b11, 1'b1, 1'b0, 32'h0, 4'b1101, 0};
        drive(va);
        @(posedge clk); #1;
        chk("abort_start", {31'd0, ctrl_start}, 32'd1);
        chk("abort_gnt", {28'd0, gnt}, 32'h2);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_ss_n_busy", {28'd0, ss_n}, 32'hD);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_rsp_rx", rsp_rx_data, 32'd0);
        chk("rst_start", {31'd0, ctrl_start}, 32'd0);
        chk("rst_ctrl_tx", ctrl_tx_data, 32'd0);
        chk("rst_ctrl_words", {30'd0, ctrl_words}, 32'd0);
        chk("rst_ctrl_tied", {31'd0, ctrl_tied_ss}, 32'd0);
        chk("rst_ss_n", {28'd0, ss_n}, 32'hF);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        seen_rsp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen_rsp = 1'b1;
        end
        chk("abort_no_rsp", {31'd0, seen_rsp}, 32'd0);

        // req[1] drops and payload changes mid-BUSY; latched values must hold.
        vb1 = '{4'b1010, 128'hFFFFFFFF_00000000_12345678_00000000, 8'b00_00_10_00, 4'b0010, 10, 32'h5EED1234,
                2'd1, 32'h12345678, 2'b10, 1'b1, 1'b0, 32'h5EED1234, 4'b1101, 11};
        run_txn(vb1, 4, 4'b1000);
        vb2 = '{4'b1000, 128'h0, 8'b0, 4'b0, 2, 32'h00C0FFEE,
                2'd3, 32'h00000000, 2'b00, 1'b0, 1'b0, 32'h00C0FFEE, 4'b0111, 3};
        run_txn(vb2, 0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
